// File: rtl/mem_req_bridge_pkg.sv
// ---------------------------------------------------------------------------
// mem_req_bridge_pkg
// Shared types and helpers for the pipeline-to-SRAM-bus request bridge.
//   size_e     : access size encoding carried on cpu_size / bus_size
//   cnt_width  : width of a counter that must hold the values 0..depth
// ---------------------------------------------------------------------------
package mem_req_bridge_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mem_req_bridge_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO.
//   clk, srst  : clock, synchronous active-high reset
//   push/wdata : write one entry (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   clear      : empty the FIFO this edge; takes priority over push/pop
//   rdata      : current head entry, valid while !empty
//   full, empty, count : occupancy status
// ---------------------------------------------------------------------------
module sync_fifo
  import mem_req_bridge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push, do_pop;

  assign full    = (count_reg == DEPTH[CW-1:0]);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;

  // Head is read combinationally so an entry written at edge N is visible
  // during cycle N+1.
  assign rdata = mem[rd_ptr_reg];

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mem_req_bridge.sv
// ---------------------------------------------------------------------------
// mem_req_bridge
// Bridges a pipeline memory port to an SRAM-like req/addr_ok/data_ok bus with
// up to DEPTH outstanding-plus-buffered in-order transactions.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : cancel in-flight reads and buffered responses
//   cpu_req_*       : request from pipeline (valid/ready, wr, size, wstrb,
//                     addr, wdata)
//   cpu_rsp_*       : buffered response to pipeline (valid/ready, rdata, wr)
//   bus_*           : SRAM-like bus master side
//   proto_err       : sticky; data_ok seen with nothing outstanding
// ---------------------------------------------------------------------------
module mem_req_bridge
  import mem_req_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                cpu_req_valid,
  output logic                cpu_req_ready,
  input  logic                cpu_wr,
  input  logic [1:0]          cpu_size,
  input  logic [DATA_W/8-1:0] cpu_wstrb,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_rsp_valid,
  input  logic                cpu_rsp_ready,
  output logic [DATA_W-1:0]   cpu_rsp_rdata,
  output logic                cpu_rsp_wr,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [1:0]          bus_size,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                proto_err
);

  localparam int CW = cnt_width(DEPTH);

  logic [CW-1:0] outst_reg, outst_next;
  logic [CW-1:0] discard_reg, discard_next;
  logic          proto_err_reg, proto_err_next;

  logic [CW-1:0] rsp_count, wr_count;
  logic          rsp_full, rsp_empty, wr_full, wr_empty;
  logic          wr_head;
  logic [DATA_W:0] rsp_wdata, rsp_rdata;

  logic credit, accept, dok_live, dok_drop, rsp_push, rsp_pop;

  // Counting buffered responses in the credit keeps a data_ok from ever
  // finding the response FIFO full.
  assign credit   = ({1'b0, outst_reg} + {1'b0, rsp_count}) < DEPTH[CW:0];
  assign bus_req  = cpu_req_valid & credit & ~flush & ~rst;
  assign accept   = bus_req & bus_addr_ok;
  assign cpu_req_ready = accept;

  assign bus_wr    = cpu_wr;
  assign bus_size  = cpu_size;
  assign bus_wstrb = cpu_wstrb;
  assign bus_addr  = cpu_addr;
  assign bus_wdata = cpu_wdata;

  // A data_ok with nothing outstanding is a slave error and otherwise ignored.
  assign dok_live  = bus_data_ok & (outst_reg != '0);
  assign dok_drop  = dok_live & (flush | (discard_reg != '0));
  assign rsp_push  = dok_live & ~dok_drop;
  assign rsp_wdata = {wr_head, wr_head ? {DATA_W{1'b0}} : bus_rdata};
  assign rsp_pop   = ~rsp_empty & cpu_rsp_ready;

  always_comb begin
    outst_next     = outst_reg + CW'(accept) - CW'(dok_live);
    discard_next   = discard_reg;
    proto_err_next = proto_err_reg | (bus_data_ok & (outst_reg == '0));
    if (flush) begin
      // Everything still outstanding after this edge belongs to the
      // cancelled stream, including stores.
      discard_next = outst_next;
    end else if (dok_live && (discard_reg != '0)) begin
      discard_next = discard_reg - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outst_reg     <= '0;
      discard_reg   <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      outst_reg     <= outst_next;
      discard_reg   <= discard_next;
      proto_err_reg <= proto_err_next;
    end
  end

  sync_fifo #(.WIDTH(DATA_W + 1), .DEPTH(DEPTH)) u_rsp_fifo (
    .clk   (clk),
    .srst  (rst),
    .push  (rsp_push),
    .pop   (rsp_pop),
    .clear (flush),
    .wdata (rsp_wdata),
    .rdata (rsp_rdata),
    .full  (rsp_full),
    .empty (rsp_empty),
    .count (rsp_count)
  );

  // Write flags stay aligned with the bus even across a flush, since
  // accepted stores still return a data_ok.
  sync_fifo #(.WIDTH(1), .DEPTH(DEPTH)) u_wr_q (
    .clk   (clk),
    .srst  (rst),
    .push  (accept),
    .pop   (dok_live),
    .clear (1'b0),
    .wdata (cpu_wr),
    .rdata (wr_head),
    .full  (wr_full),
    .empty (wr_empty),
    .count (wr_count)
  );

  assign cpu_rsp_valid = ~rsp_empty;
  assign cpu_rsp_wr    = rsp_rdata[DATA_W];
  assign cpu_rsp_rdata = rsp_rdata[DATA_W-1:0];
  assign proto_err     = proto_err_reg;

  // Status outputs not needed by this bridge.
  logic unused_status;
  assign unused_status = &{1'b0, rsp_full, wr_full, wr_empty, wr_count};

endmodule

// File: tb/tb_mem_req_bridge.sv
// ---------------------------------------------------------------------------
// tb_mem_req_bridge
// Cycle table drives the bridge and bus side; per-row expected handshake and
// status outputs are checked mid-cycle. Delivered responses are checked
// against a scoreboard queue filled when the matching data_ok is driven.
// ---------------------------------------------------------------------------
module tb_mem_req_bridge;
  import mem_req_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        cpu_req_valid, cpu_req_ready, cpu_wr;
  logic [1:0]  cpu_size;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_rsp_valid, cpu_rsp_ready, cpu_rsp_wr;
  logic [31:0] cpu_rsp_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;
  logic        proto_err;

  always #5 clk = ~clk;

  mem_req_bridge #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_wstrb(cpu_wstrb),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready),
    .cpu_rsp_rdata(cpu_rsp_rdata), .cpu_rsp_wr(cpu_rsp_wr),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_wstrb(bus_wstrb), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .proto_err(proto_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] sb[$];

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic rst, fl, rv, wr;
    logic [31:0] addr;
    logic aok, dok;
    logic [31:0] rd;
    logic rr;
    logic e_breq, e_rdy, e_rv, e_perr;
    logic keep, kwr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic rst_i, fl, rv, wr, input logic [31:0] addr,
                             input logic aok, dok, input logic [31:0] rd, input logic rr,
                             input logic e_breq, e_rdy, e_rv, e_perr, input logic keep, kwr);
    vec_t r;
    r.rst = rst_i; r.fl = fl; r.rv = rv; r.wr = wr; r.addr = addr;
    r.aok = aok; r.dok = dok; r.rd = rd; r.rr = rr;
    r.e_breq = e_breq; r.e_rdy = e_rdy; r.e_rv = e_rv; r.e_perr = e_perr;
    r.keep = keep; r.kwr = kwr;
    return r;
  endfunction

  task automatic apply(input vec_t r);
    rst = r.rst; flush = r.fl; cpu_req_valid = r.rv; cpu_wr = r.wr;
    cpu_addr = r.addr; cpu_wdata = ~r.addr; cpu_wstrb = r.wr ? 4'hF : 4'h0;
    cpu_size = SIZE_WORD; bus_addr_ok = r.aok; bus_data_ok = r.dok;
    bus_rdata = r.rd; cpu_rsp_ready = r.rr;
    if (r.keep) sb.push_back({r.kwr, r.kwr ? 32'h0 : r.rd});
  endtask

  // Response monitor: every handshake pops one expected entry.
  always @(negedge clk) begin
    if (cpu_rsp_valid === 1'b1 && cpu_rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got wr=%0d rdata=0x%0h with no response due",
                 cpu_rsp_wr, cpu_rsp_rdata);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        check("rsp", {31'h0, cpu_rsp_wr, cpu_rsp_rdata}, {31'h0, e});
        $display("[TB] rsp wr=%0d rdata=0x%08h", cpu_rsp_wr, cpu_rsp_rdata);
      end
    end
  end

  initial begin
    // rst, fl, rv, wr, addr, aok, dok, rd, rr | breq, rdy, rv, perr | keep, kwr
    vecs.push_back(v(1,0,1,0,32'h1000,1,0,32'h0,0, 0,0,0,0, 0,0));
    // back-to-back loads, fifth held for credit
    vecs.push_back(v(0,0,1,0,32'h1000,1,0,32'h0,1, 1,1,0,0, 0,0));
    vecs.push_back(v(0,0,1,0,32'h1004,1,0,32'h0,1, 1,1,0,0, 0,0));
    vecs.push_back(v(0,0,1,0,32'h1008,1,0,32'h0,1, 1,1,0,0, 0,0));
    vecs.push_back(v(0,0,1,0,32'h100C,1,1,32'hA,1, 1,1,0,0, 1,0));
    vecs.push_back(v(0,0,1,0,32'h1010,1,1,32'hB,1, 0,0,1,0, 1,0));
    vecs.push_back(v(0,0,1,0,32'h1010,1,1,32'hC,1, 1,1,1,0, 1,0));
    vecs.push_back(v(0,0,0,0,32'h0,0,1,32'hD,1,    0,0,1,0, 1,0));
    vecs.push_back(v(0,0,0,0,32'h0,0,1,32'hE,1,    0,0,1,0, 1,0));
    vecs.push_back(v(0,0,0,0,32'h0,0,0,32'h0,1,    0,0,1,0, 0,0));
    vecs.push_back(v(0,0,0,0,32'h0,0,0,32'h0,1,    0,0,0,0, 0,0));
    // stalled pipeline fills the response FIFO
    vecs.push_back(v(0,0,1,0,32'h3000,1,0,32'h0,0,  1,1,0,0, 0,0));
    vecs.push_back(v(0,0,1,0,32'h3004,1,1,32'h11,0, 1,1,0,0, 1,0));
    vecs.push_back(v(0,0,1,0,32'h3008,1,1,32'h22,0, 1,1,1,0, 1,0));
    vecs.push_back(v(0,0,1,0,32'h300C,1,1,32'h33,0, 1,1,1,0, 1,0));
    vecs.push_back(v(0,0,1,0,32'h3010,1,1,32'h44,0, 0,0,1,0, 1,0));
    vecs.push_back(v(0,0,1,0,32'h3010,1,0,32'h0,0,  0,0,1,0, 0,0));
    vecs.push_back(v(0,0,1,0,32'h3010,1,0,32'h0,1,  0,0,1,0, 0,0));
    vecs.push_back(v(0,0,1,0,32'h3010,1,0,32'h0,1,  1,1,1,0, 0,0));
    vecs.push_back(v(0,0,0,0,32'h0,0,0,32'h0,1,     0,0,1,0, 0,0));
    vecs.push_back(v(0,0,0,0,32'h0,0,1,32'h55,1,    0,0,1,0, 1,0));
    vecs.push_back(v(0,0,0,0,32'h0,0,0,32'h0,1,     0,0,1,0, 0,0));
    // flush with three loads in flight
    vecs.push_back(v(0,0,1,0,32'h4000,1,0,32'h0,1,  1,1,0,0, 0,0));
    vecs.push_back(v(0,0,1,0,32'h4004,1,0,32'h0,1,  1,1,0,0, 0,0));
    vecs.push_back(v(0,0,1,0,32'h4008,1,0,32'h0,1,  1,1,0,0, 0,0));
    vecs.push_back(v(0,1,1,0,32'h400C,1,0,32'h0,1,  0,0,0,0, 0,0));
    vecs.push_back(v(0,0,0,0,32'h0,0,1,32'h66,1,    0,0,0,0, 0,0));
    vecs.push_back(v(0,0,0,0,32'h0,0,1,32'h77,1,    0,0,0,0, 0,0));
    vecs.push_back(v(0,0,1,0,32'h5000,1,1,32'h88,1, 1,1,0,0, 0,0));
    vecs.push_back(v(0,0,0,0,32'h0,0,1,32'h99,1,    0,0,0,0, 1,0));
    vecs.push_back(v(0,0,0,0,32'h0,0,0,32'h0,1,     0,0,1,0, 0,0));
    // flush clears a buffered response and drops a same-cycle data_ok
    vecs.push_back(v(0,0,1,0,32'h6000,1,0,32'h0,0,  1,1,0,0, 0,0));
    vecs.push_back(v(0,0,1,0,32'h6004,1,1,32'hAB,0, 1,1,0,0, 0,0));
    vecs.push_back(v(0,1,0,0,32'h0,0,1,32'hCD,0,    0,0,1,0, 0,0));
    vecs.push_back(v(0,0,0,0,32'h0,0,0,32'h0,1,     0,0,0,0, 0,0));
    // store then load to the same address
    vecs.push_back(v(0,0,1,1,32'h2000,1,0,32'h0,1,        1,1,0,0, 0,0));
    vecs.push_back(v(0,0,1,0,32'h2000,1,1,32'hFFFFFFFF,1, 1,1,0,0, 1,1));
    vecs.push_back(v(0,0,0,0,32'h0,0,1,32'h1234,1,        0,0,1,0, 1,0));
    vecs.push_back(v(0,0,0,0,32'h0,0,0,32'h0,1,           0,0,1,0, 0,0));
    // stray data_ok raises sticky error, traffic still works
    vecs.push_back(v(0,0,0,0,32'h0,0,1,32'hBAD,1,   0,0,0,0, 0,0));
    vecs.push_back(v(0,0,1,0,32'h7000,1,0,32'h0,1,  1,1,0,1, 0,0));
    vecs.push_back(v(0,0,0,0,32'h0,0,1,32'h42,1,    0,0,0,1, 1,0));
    vecs.push_back(v(0,0,0,0,32'h0,0,0,32'h0,1,     0,0,1,1, 0,0));
    // reset mid-stream, then a late data_ok
    vecs.push_back(v(0,0,1,0,32'h8000,1,0,32'h0,0,  1,1,0,1, 0,0));
    vecs.push_back(v(0,0,0,0,32'h0,0,1,32'h5A,0,    0,0,0,1, 0,0));
    vecs.push_back(v(1,0,1,0,32'h8004,1,0,32'h0,0,  0,0,1,1, 0,0));
    vecs.push_back(v(0,0,0,0,32'h0,0,0,32'h0,1,     0,0,0,0, 0,0));
    vecs.push_back(v(0,0,0,0,32'h0,0,1,32'h77,1,    0,0,0,0, 0,0));
    vecs.push_back(v(0,0,0,0,32'h0,0,0,32'h0,1,     0,0,0,1, 0,0));

    apply(v(1,0,0,0,32'h0,0,0,32'h0,0, 0,0,0,0, 0,0));
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      apply(vecs[i]);
      @(negedge clk);
      check($sformatf("row%0d bus_req", i), {63'h0, bus_req}, {63'h0, vecs[i].e_breq});
      check($sformatf("row%0d cpu_req_ready", i), {63'h0, cpu_req_ready}, {63'h0, vecs[i].e_rdy});
      check($sformatf("row%0d cpu_rsp_valid", i), {63'h0, cpu_rsp_valid}, {63'h0, vecs[i].e_rv});
      check($sformatf("row%0d proto_err", i), {63'h0, proto_err}, {63'h0, vecs[i].e_perr});
      if (vecs[i].rv) begin
        check($sformatf("row%0d bus_addr", i), {32'h0, bus_addr}, {32'h0, vecs[i].addr});
        check($sformatf("row%0d bus_fields", i),
              {25'h0, bus_wr, bus_size, bus_wstrb, bus_wdata},
              {25'h0, vecs[i].wr, 2'd2, (vecs[i].wr ? 4'hF : 4'h0), ~vecs[i].addr});
      end
      $display("[TB] row %0d req=%0d rdy=%0d rsp_v=%0d perr=%0d",
               i, bus_req, cpu_req_ready, cpu_rsp_valid, proto_err);
    end

    // Hand-written: request waits on addr_ok, then a bounded wait for data.
    @(posedge clk); #1;
    apply(v(0,0,1,0,32'h9000,0,0,32'h0,0, 0,0,0,0, 0,0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("wait%0d bus_req", k), {63'h0, bus_req}, 64'h1);
      check($sformatf("wait%0d cpu_req_ready", k), {63'h0, cpu_req_ready}, 64'h0);
      @(posedge clk); #1;
    end
    bus_addr_ok = 1'b1;
    @(negedge clk);
    check("wait_accept cpu_req_ready", {63'h0, cpu_req_ready}, 64'h1);
    @(posedge clk); #1;
    apply(v(0,0,0,0,32'h0,0,1,32'h9999,1, 0,0,0,0, 1,0));
    @(posedge clk); #1;
    bus_data_ok = 1'b0;
    for (int k = 0; k < 8 && sb.size() != 0; k++) @(posedge clk);
    #1;
    check("scoreboard_drained", {32'h0, sb.size()}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
